// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file.
//
// Holds Status, Cause, EPC, BadVAddr, EntryHi, EBase and, optionally, the
// Count/Compare timer. Exception and ERET commits come from the exception
// detector. MTC0 writes come from write-back. MFC0 reads are combinational.
// Interrupt and vector state is fed back to the detector.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   - Count (9/0) and Compare (11/0) are built and drive timer_int.
//   undefined - no timer state; 9/0 and 11/0 read 0, timer_int is 0.
//
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous reset, active-high (1 = reset)
//   rd_addr/rd_sel  MFC0 register number / select
//   rd_data         MFC0 read data (0 for unimplemented registers)
//   we, wr_addr, wr_sel, wr_data   MTC0 write port
//   hw_int_in       raw external interrupt lines
//   exp_in          exception commit
//   exp_clean_exl   ERET commit
//   exp_epc, exp_bd, exp_code      return PC, delay-slot flag, ExcCode
//   exp_bad_vaddr, exp_badv_we     BadVAddr value / load enable
//   exp_asid, exp_asid_we          EntryHi refill values / load enable
//   interrupt_mask, hardware_int, software_int, allow_int, exl,
//   boot_exp_vec, special_int_vec, ebase_out, epc_out, asid_out,
//   timer_int       state fed back to the pipeline
module cp0_regfile #(
    parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr,
    input  logic [2:0]  rd_sel,
    output logic [31:0] rd_data,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [5:0]  hw_int_in,
    input  logic        exp_in,
    input  logic        exp_clean_exl,
    input  logic [31:0] exp_epc,
    input  logic        exp_bd,
    input  logic [4:0]  exp_code,
    input  logic [31:0] exp_bad_vaddr,
    input  logic        exp_badv_we,
    input  logic [7:0]  exp_asid,
    input  logic        exp_asid_we,
    output logic [7:0]  interrupt_mask,
    output logic [5:0]  hardware_int,
    output logic [1:0]  software_int,
    output logic        allow_int,
    output logic        exl,
    output logic        boot_exp_vec,
    output logic        special_int_vec,
    output logic [19:0] ebase_out,
    output logic [31:0] epc_out,
    output logic [7:0]  asid_out,
    output logic        timer_int
);

    // Register keys are {address, select}.
    localparam logic [7:0] REG_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] REG_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] REG_ENTRYHI  = {5'd10, 3'd0};
    localparam logic [7:0] REG_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] REG_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] REG_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] REG_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] REG_EBASE    = {5'd15, 3'd1};

    // Status fields
    logic        status_bev;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    // Cause fields
    logic        cause_bd;
    logic        cause_iv;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;
    // Remaining registers
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [18:0] entryhi_vpn2;
    logic [7:0]  entryhi_asid;
    logic [17:0] ebase_q;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;

    // Low page-offset bits of the bad address never reach EntryHi.
    logic unused_bits;
    assign unused_bits = ^exp_bad_vaddr[12:0];

    // An MTC0 travelling with an exception or ERET commit is being flushed.
    logic       mtc0;
    logic [7:0] wr_key;
    assign mtc0   = we & ~exp_in & ~exp_clean_exl;
    assign wr_key = {wr_addr, wr_sel};

    logic wr_entryhi, wr_status, wr_cause, wr_epc, wr_ebase;
    assign wr_entryhi = mtc0 && (wr_key == REG_ENTRYHI);
    assign wr_status  = mtc0 && (wr_key == REG_STATUS);
    assign wr_cause   = mtc0 && (wr_key == REG_CAUSE);
    assign wr_epc     = mtc0 && (wr_key == REG_EPC);
    assign wr_ebase   = mtc0 && (wr_key == REG_EBASE);

`ifdef CP0_TIMER_EN
    logic        wr_count, wr_compare;
    logic [31:0] count_q, compare_q, count_next;
    logic        timer_q;

    assign wr_count   = mtc0 && (wr_key == REG_COUNT);
    assign wr_compare = mtc0 && (wr_key == REG_COMPARE);

    // A Count write replaces the increment for that cycle.
    always_comb begin
        count_next = count_q + 32'd1;
        if (wr_count) count_next = wr_data;
    end

    // The match looks at the value Count takes on this edge, so timer_int
    // rises in the same cycle that Count reads equal to Compare.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q <= count_next;
            if (wr_compare) begin
                compare_q <= wr_data;
                timer_q   <= 1'b0;
            end else if (count_next == compare_q) begin
                timer_q <= 1'b1;
            end
        end
    end

    assign timer_int  = timer_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign timer_int  = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            status_bev   <= 1'b1;
            status_im    <= '0;
            status_exl   <= 1'b0;
            status_ie    <= 1'b0;
            cause_bd     <= 1'b0;
            cause_iv     <= 1'b0;
            cause_ip_hw  <= '0;
            cause_ip_sw  <= '0;
            cause_exc    <= '0;
            epc_q        <= '0;
            badvaddr_q   <= '0;
            entryhi_vpn2 <= '0;
            entryhi_asid <= '0;
            ebase_q      <= EBASE_RESET[29:12];
        end else begin
            // IP[15] also carries the (registered) timer interrupt.
            cause_ip_hw <= {hw_int_in[5] | timer_int, hw_int_in[4:0]};

            if (exp_in) begin
                status_exl <= 1'b1;
                cause_exc  <= exp_code;
                // Nested exceptions keep the original return point.
                if (!status_exl) begin
                    epc_q    <= exp_epc;
                    cause_bd <= exp_bd;
                end
                if (exp_badv_we) badvaddr_q <= exp_bad_vaddr;
                if (exp_asid_we) begin
                    entryhi_vpn2 <= exp_bad_vaddr[31:13];
                    entryhi_asid <= exp_asid;
                end
            end else if (exp_clean_exl) begin
                status_exl <= 1'b0;
            end

            if (wr_status) begin
                status_bev <= wr_data[22];
                status_im  <= wr_data[15:8];
                status_exl <= wr_data[1];
                status_ie  <= wr_data[0];
            end
            if (wr_cause) begin
                cause_iv    <= wr_data[23];
                cause_ip_sw <= wr_data[9:8];
            end
            if (wr_entryhi) begin
                entryhi_vpn2 <= wr_data[31:13];
                entryhi_asid <= wr_data[7:0];
            end
            if (wr_epc)   epc_q   <= wr_data;
            if (wr_ebase) ebase_q <= wr_data[29:12];
        end
    end

    always_comb begin
        rd_data = '0;
        case ({rd_addr, rd_sel})
            REG_BADVADDR: rd_data = badvaddr_q;
            REG_COUNT:    rd_data = count_rd;
            REG_ENTRYHI:  rd_data = {entryhi_vpn2, 5'b0, entryhi_asid};
            REG_COMPARE:  rd_data = compare_rd;
            REG_STATUS:   rd_data = {9'b0, status_bev, 6'b0, status_im,
                                     6'b0, status_exl, status_ie};
            REG_CAUSE:    rd_data = {cause_bd, 7'b0, cause_iv, 7'b0,
                                     cause_ip_hw, cause_ip_sw, 1'b0,
                                     cause_exc, 2'b0};
            REG_EPC:      rd_data = epc_q;
            REG_EBASE:    rd_data = {2'b10, ebase_q, 12'b0};
            default:      rd_data = '0;
        endcase
    end

    assign interrupt_mask  = status_im;
    assign hardware_int    = cause_ip_hw;
    assign software_int    = cause_ip_sw;
    assign allow_int       = status_ie & ~status_exl;
    assign exl             = status_exl;
    assign boot_exp_vec    = status_bev;
    assign special_int_vec = cause_iv;
    assign ebase_out       = {2'b10, ebase_q};
    assign epc_out         = epc_q;
    assign asid_out        = entryhi_asid;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: a register-level reference model (whole 32-bit
// registers updated through write masks) is checked against every DUT output
// on each falling edge, with directed scenarios pinning literal values and a
// randomized phase covering mixed commits, MTC0 traffic and resets.
module tb_cp0_regfile;

    localparam logic [31:0] EBASE_RESET = 32'h8000_0000;
`ifdef CP0_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [5:0]  hw_int_in;
    logic        exp_in;
    logic        exp_clean_exl;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic [4:0]  exp_code;
    logic [31:0] exp_bad_vaddr;
    logic        exp_badv_we;
    logic [7:0]  exp_asid;
    logic        exp_asid_we;
    logic [7:0]  interrupt_mask;
    logic [5:0]  hardware_int;
    logic [1:0]  software_int;
    logic        allow_int;
    logic        exl;
    logic        boot_exp_vec;
    logic        special_int_vec;
    logic [19:0] ebase_out;
    logic [31:0] epc_out;
    logic [7:0]  asid_out;
    logic        timer_int;

    int checks = 0;
    int passed = 0;

    cp0_regfile #(.EBASE_RESET(EBASE_RESET)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
        .we(we), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
        .hw_int_in(hw_int_in),
        .exp_in(exp_in), .exp_clean_exl(exp_clean_exl),
        .exp_epc(exp_epc), .exp_bd(exp_bd), .exp_code(exp_code),
        .exp_bad_vaddr(exp_bad_vaddr), .exp_badv_we(exp_badv_we),
        .exp_asid(exp_asid), .exp_asid_we(exp_asid_we),
        .interrupt_mask(interrupt_mask), .hardware_int(hardware_int),
        .software_int(software_int), .allow_int(allow_int), .exl(exl),
        .boot_exp_vec(boot_exp_vec), .special_int_vec(special_int_vec),
        .ebase_out(ebase_out), .epc_out(epc_out), .asid_out(asid_out),
        .timer_int(timer_int)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_badv, m_count, m_entryhi, m_compare;
    logic [31:0] m_status, m_cause, m_epc, m_ebase;
    logic        m_timer;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] wmask(input logic [4:0] a, input logic [2:0] s);
        if (s == 3'd1 && a == 5'd15) return 32'h3FFF_F000;
        if (s != 3'd0) return 32'h0;
        case (a)
            5'd9, 5'd11: return TIMER_EN ? 32'hFFFF_FFFF : 32'h0;
            5'd10:       return 32'hFFFF_E0FF;
            5'd12:       return 32'h0040_FF03;
            5'd13:       return 32'h0080_0300;
            5'd14:       return 32'hFFFF_FFFF;
            default:     return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s == 3'd1 && a == 5'd15) return (m_ebase & 32'h3FFF_F000) | 32'h8000_0000;
        if (s != 3'd0) return 32'h0;
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd10:   return m_entryhi;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] st, ca, ep, bv, eh, cn, cp, eb, mk, merged;
        logic        tm, mtc0, cmp_wr;
        m_valid <= 1'b1;
        if (rst_n) begin
            m_status  <= 32'h0040_0000;
            m_ebase   <= EBASE_RESET;
            m_cause   <= '0;
            m_epc     <= '0;
            m_badv    <= '0;
            m_entryhi <= '0;
            m_count   <= '0;
            m_compare <= '0;
            m_timer   <= 1'b0;
        end else begin
            st = m_status; ca = m_cause; ep = m_epc; bv = m_badv;
            eh = m_entryhi; cn = m_count; cp = m_compare; eb = m_ebase;
            tm = m_timer; cmp_wr = 1'b0;
            mtc0 = we && !exp_in && !exp_clean_exl;
            ca[15:10] = {hw_int_in[5] | m_timer, hw_int_in[4:0]};
            if (exp_in) begin
                if (!m_status[1]) begin
                    ep = exp_epc;
                    ca[31] = exp_bd;
                end
                st[1] = 1'b1;
                ca[6:2] = exp_code;
                if (exp_badv_we) bv = exp_bad_vaddr;
                if (exp_asid_we) eh = {exp_bad_vaddr[31:13], 5'b0, exp_asid};
            end else if (exp_clean_exl) begin
                st[1] = 1'b0;
            end
            if (TIMER_EN) cn = m_count + 32'd1;
            if (mtc0) begin
                mk = wmask(wr_addr, wr_sel);
                if (wr_sel == 3'd1 && wr_addr == 5'd15) eb = (eb & ~mk) | (wr_data & mk);
                else if (wr_sel == 3'd0) begin
                    case (wr_addr)
                        5'd9:  cn = (m_count & ~mk) | (wr_data & mk);
                        5'd10: eh = (eh & ~mk) | (wr_data & mk);
                        5'd11: begin
                            merged = (cp & ~mk) | (wr_data & mk);
                            cp = merged;
                            cmp_wr = TIMER_EN;
                        end
                        5'd12: st = (st & ~mk) | (wr_data & mk);
                        5'd13: ca = (ca & ~mk) | (wr_data & mk);
                        5'd14: ep = (ep & ~mk) | (wr_data & mk);
                        default: ;
                    endcase
                end
            end
            if (TIMER_EN) begin
                if (cmp_wr) tm = 1'b0;
                else if (cn == m_compare) tm = 1'b1;
            end
            m_status <= st; m_cause <= ca; m_epc <= ep; m_badv <= bv;
            m_entryhi <= eh; m_count <= cn; m_compare <= cp; m_ebase <= eb;
            m_timer <= tm;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check32("rd_data", rd_data, m_read(rd_addr, rd_sel));
            check32("interrupt_mask", {24'b0, interrupt_mask}, {24'b0, m_status[15:8]});
            check32("hardware_int", {26'b0, hardware_int}, {26'b0, m_cause[15:10]});
            check32("software_int", {30'b0, software_int}, {30'b0, m_cause[9:8]});
            check32("allow_int", {31'b0, allow_int}, {31'b0, m_status[0] & ~m_status[1]});
            check32("exl", {31'b0, exl}, {31'b0, m_status[1]});
            check32("boot_exp_vec", {31'b0, boot_exp_vec}, {31'b0, m_status[22]});
            check32("special_int_vec", {31'b0, special_int_vec}, {31'b0, m_cause[23]});
            check32("ebase_out", {12'b0, ebase_out}, {12'b0, 2'b10, m_ebase[29:12]});
            check32("epc_out", epc_out, m_epc);
            check32("asid_out", {24'b0, asid_out}, {24'b0, m_entryhi[7:0]});
            check32("timer_int", {31'b0, timer_int}, {31'b0, m_timer});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        we = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0;
        exp_in = 1'b0; exp_clean_exl = 1'b0; exp_epc = '0; exp_bd = 1'b0;
        exp_code = '0; exp_bad_vaddr = '0; exp_badv_we = 1'b0;
        exp_asid = '0; exp_asid_we = 1'b0;
    endtask

    // Inputs set before this call are sampled by the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mtc0_wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        #1;
        we = 1'b1; wr_addr = a; wr_sel = s; wr_data = d;
        step();
    endtask

    task automatic commit_exc(input logic [31:0] epc, input logic bd, input logic [4:0] code,
                              input logic [31:0] badv, input logic badv_we,
                              input logic [7:0] asid, input logic asid_we);
        #1;
        exp_in = 1'b1; exp_epc = epc; exp_bd = bd; exp_code = code;
        exp_bad_vaddr = badv; exp_badv_we = badv_we;
        exp_asid = asid; exp_asid_we = asid_we;
        step();
    endtask

    task automatic eret();
        #1;
        exp_clean_exl = 1'b1;
        step();
    endtask

    task automatic peek(input logic [4:0] a, input logic [2:0] s);
        #1;
        rd_addr = a; rd_sel = s;
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        logic [4:0] a;
        idle();
        hw_int_in = '0; rd_addr = 5'd12; rd_sel = 3'd0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        check32("rst_bev", {31'b0, boot_exp_vec}, 32'd1);
        check32("rst_allow_int", {31'b0, allow_int}, 32'd0);
        check32("rst_status", rd_data, 32'h0040_0000);
        check32("rst_ebase_out", {12'b0, ebase_out}, 32'h0008_0000);
        peek(5'd15, 3'd1);
        check32("rst_ebase", rd_data, 32'h8000_0000);

        // Enable interrupts, then one external line
        mtc0_wr(5'd12, 3'd0, 32'h0000_FF01);
        @(negedge clk);
        check32("ie_allow_int", {31'b0, allow_int}, 32'd1);
        check32("ie_mask", {24'b0, interrupt_mask}, 32'h0000_00FF);
        #1 hw_int_in = 6'b000001;
        #1 check32("hw_latency0", {26'b0, hardware_int}, 32'd0);
        @(negedge clk);
        check32("hw_latency1", {26'b0, hardware_int}, 32'd1);
        #1 hw_int_in = '0;
        step();

        // Exception commit, then a nested one
        commit_exc(32'h8000_0100, 1'b1, 5'h0c, 32'h0, 1'b0, 8'h0, 1'b0);
        peek(5'd13, 3'd0);
        check32("exc_cause", rd_data, 32'h8000_0030);
        check32("exc_epc", epc_out, 32'h8000_0100);
        check32("exc_exl", {31'b0, exl}, 32'd1);
        check32("exc_allow_int", {31'b0, allow_int}, 32'd0);
        commit_exc(32'h8000_0200, 1'b0, 5'h0c, 32'h0, 1'b0, 8'h0, 1'b0);
        @(negedge clk);
        check32("nested_epc", epc_out, 32'h8000_0100);
        eret();
        @(negedge clk);
        check32("eret_exl", {31'b0, exl}, 32'd0);

        // TLB-miss style commit
        commit_exc(32'h8000_0180, 1'b0, 5'h02, 32'h0040_1234, 1'b1, 8'h5A, 1'b1);
        peek(5'd8, 3'd0);
        check32("tlb_badv", rd_data, 32'h0040_1234);
        peek(5'd10, 3'd0);
        check32("tlb_entryhi", rd_data, 32'h0040_005A);
        check32("tlb_asid_out", {24'b0, asid_out}, 32'h0000_005A);
        eret();

        // Exception with a same-cycle MTC0 to EPC: MTC0 dropped
        #1;
        we = 1'b1; wr_addr = 5'd14; wr_sel = 3'd0; wr_data = 32'hDEAD_BEEF;
        commit_exc(32'h8000_0300, 1'b0, 5'h04, 32'h0, 1'b0, 8'h0, 1'b0);
        @(negedge clk);
        check32("flush_epc", epc_out, 32'h8000_0300);
        eret();

        // Exception and ERET together: exception wins
        #1 exp_clean_exl = 1'b1;
        commit_exc(32'h8000_0400, 1'b0, 5'h08, 32'h0, 1'b0, 8'h0, 1'b0);
        @(negedge clk);
        check32("exc_wins_exl", {31'b0, exl}, 32'd1);
        check32("exc_wins_epc", epc_out, 32'h8000_0400);

        // ERET with a same-cycle MTC0 clearing Status: MTC0 dropped
        #1;
        we = 1'b1; wr_addr = 5'd12; wr_sel = 3'd0; wr_data = 32'h0;
        eret();
        peek(5'd12, 3'd0);
        check32("eret_flush_status", rd_data, 32'h0000_FF01);

        // Timer
        if (TIMER_EN) begin
            mtc0_wr(5'd11, 3'd0, 32'd10);
            mtc0_wr(5'd9, 3'd0, 32'd0);
            peek(5'd9, 3'd0);
            check32("count_start", rd_data, 32'd0);
            for (int i = 0; i < 30 && !timer_int; i++) @(negedge clk);
            check32("timer_set", {31'b0, timer_int}, 32'd1);
            check32("timer_count", rd_data, 32'd10);
            peek(5'd13, 3'd0);
            check32("timer_ip7", {31'b0, rd_data[15]}, 32'd1);
            mtc0_wr(5'd11, 3'd0, 32'd100);
            peek(5'd11, 3'd0);
            check32("timer_clear", {31'b0, timer_int}, 32'd0);
            check32("compare_rd", rd_data, 32'd100);
        end else begin
            mtc0_wr(5'd9, 3'd0, 32'd55);
            mtc0_wr(5'd11, 3'd0, 32'd56);
            peek(5'd9, 3'd0);
            check32("no_count", rd_data, 32'd0);
            peek(5'd11, 3'd0);
            check32("no_compare", rd_data, 32'd0);
            check32("no_timer", {31'b0, timer_int}, 32'd0);
        end

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 2) == 0);
            a = 5'($urandom_range(8, 15));
            wr_addr = a;
            wr_sel = (a == 5'd15) ? 3'd1 : 3'd0;
            if ($urandom_range(0, 9) == 0) wr_sel = 3'($urandom_range(0, 7));
            wr_data = $urandom;
            if (TIMER_EN && a == 5'd9 && $urandom_range(0, 1) == 1)
                wr_data = m_compare - 32'($urandom_range(1, 4));
            hw_int_in = 6'($urandom_range(0, 63));
            exp_in = ($urandom_range(0, 9) == 0);
            exp_clean_exl = ($urandom_range(0, 7) == 0);
            exp_epc = $urandom;
            exp_bd = 1'($urandom_range(0, 1));
            exp_code = 5'($urandom_range(0, 31));
            exp_bad_vaddr = $urandom;
            exp_badv_we = 1'($urandom_range(0, 1));
            exp_asid = 8'($urandom_range(0, 255));
            exp_asid_we = 1'($urandom_range(0, 1));
            rd_addr = 5'($urandom_range(0, 16));
            rd_sel = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
        end
        #1;
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
